half_subtractor_core: RTL and testbench
=======================================

# half_subtractor_core

Registered single-bit half subtractor, replicated across WIDTH independent lanes, computing diff = a XOR b and borrow = (NOT a) AND b per lane. It is a leaf arithmetic primitive used by larger subtractor and comparator datapaths. Outputs are captured on the clock with a valid qualifier and one cycle of latency. A saturating event counter tallies borrowing lanes for debug.

## Interface
Parameters:
- WIDTH, 1, number of independent lanes (≥1); lane i uses bit i of every vector port.
- CNT_W, 16, width of the borrow event counter (≥2).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  minuend bits.
- b  input  WIDTH  subtrahend bits.
- cnt_clr  input  1  synchronous clear of borrow_count.
- out_valid  output  1  diff/borrow hold a new result this cycle.
- diff  output  WIDTH  registered difference bits.
- borrow  output  WIDTH  registered borrow-out bits.
- borrow_count  output  CNT_W  saturating count of accepted lanes that produced borrow=1.

## Operation
- Per-lane function, no carry or borrow between lanes:
  - a=0, b=0 -> diff 0, borrow 0
  - a=0, b=1 -> diff 1, borrow 1
  - a=1, b=0 -> diff 1, borrow 0
  - a=1, b=1 -> diff 0, borrow 0
- When in_valid=1 on an edge: diff and borrow load the per-lane results, and out_valid is set to 1.
- When in_valid=0 on an edge: diff and borrow hold their previous values, and out_valid is set to 0.
- borrow_count:
  - On an edge with in_valid=1, add the number of lanes where (NOT a) AND b = 1, i.e. the population count of the borrow vector.
  - Saturate at 2^CNT_W − 1; the counter never wraps.
  - cnt_clr=1 forces the counter to 0 on that edge. It takes priority over any increment in the same cycle; that cycle's borrows are discarded.
- X or Z on a or b while in_valid=0 must not affect any register.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on diff/borrow/out_valid after edge N and remain stable until edge N+1.
- Throughput: one result per cycle, with no stall or backpressure; in_valid may stay high continuously.
- Reset (rst_n=0 at an edge) sets diff=0, borrow=0, out_valid=0, borrow_count=0.
  - Reset overrides in_valid and cnt_clr.
  - Reset asserted mid-stream discards the in-flight input.
  - The first edge with rst_n=1 and in_valid=1 produces a normal result.
- Reset has no asynchronous effect: outputs do not change between clock edges while rst_n is low.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, a=1, b=0 -> diff=0, borrow=0, out_valid=0, borrow_count=0 throughout.
- Truth table (WIDTH=1): apply {a,b}=00,01,10,11 on consecutive cycles with in_valid=1 -> one cycle later, (diff,borrow) = (0,0),(1,1),(1,0),(0,0); out_valid stays 1; borrow_count ends at 1.
- Hold: after {a,b}=01, drop in_valid to 0 and drive a=1, b=1 -> diff=1, borrow=1 held, out_valid=0, borrow_count unchanged.
- Multi-lane (WIDTH=4): a=4'b0101, b=4'b0011 -> diff=4'b0110, borrow=4'b0010, borrow_count increments by 1.
- Counter saturation and clear (CNT_W=2): apply a=0, b=1 for 5 valid cycles -> borrow_count reads 1,2,3,3,3. Then cnt_clr=1 together with a valid borrowing input -> borrow_count=0.
- Mid-stream reset: with in_valid=1 continuously, assert rst_n=0 for one edge -> outputs return to 0 that cycle, and the next valid input yields a correct result one cycle later.

Source files
------------

// File: rtl/half_subtractor_core.sv
// Registered per-lane half subtractor (diff = a^b, borrow = ~a&b) with a
// one-cycle valid qualifier and a saturating tally of borrowing lanes.
module half_subtractor_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic [CNT_W-1:0] borrow_count
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] diff_q,   diff_d;
  logic [WIDTH-1:0] borrow_q, borrow_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic [WIDTH-1:0] diff_lane;
  logic [WIDTH-1:0] borrow_lane;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;

  always_comb begin
    diff_lane   = a ^ b;
    borrow_lane = ~a & b;

    pc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(borrow_lane[i]);
    end
    // Extra headroom bit lets the saturation test see the true overflow.
    sum = SUM_W'(cnt_q) + SUM_W'(pc);

    diff_d   = diff_q;
    borrow_d = borrow_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;

    if (in_valid) begin
      diff_d   = diff_lane;
      borrow_d = borrow_lane;
      valid_d  = 1'b1;
      cnt_d    = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign diff         = diff_q;
  assign borrow       = borrow_q;
  assign borrow_count = cnt_q;

endmodule

// File: tb/tb_half_subtractor_core.sv
// Scoreboard bench for half_subtractor_core: stimulus pushes expected
// outputs per cycle, an independent monitor pops and compares after each edge.
module tb_half_subtractor_core;

  localparam int W  = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  a, b;
  logic          cnt_clr;
  logic          out_valid;
  logic [W-1:0]  diff, borrow;
  logic [CW-1:0] borrow_count;

  half_subtractor_core #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .cnt_clr      (cnt_clr),
    .out_valid    (out_valid),
    .diff         (diff),
    .borrow       (borrow),
    .borrow_count (borrow_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ov;
    logic [W-1:0]  d;
    logic [W-1:0]  br;
    logic [CW-1:0] c;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: what the outputs should look like after the next edge.
  logic [W-1:0] m_d  = '0;
  logic [W-1:0] m_br = '0;
  int           m_cnt = 0;

  // Lane-wise subtraction a_i - b_i: result bit is the value mod 2,
  // borrow is whether the true difference went negative.
  task automatic step(input logic r, input logic v, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic clr);
    exp_t e;
    int   nb;
    @(negedge clk);
    rst_n = r; in_valid = v; a = av; b = bv; cnt_clr = clr;
    if (!r) begin
      m_d = '0; m_br = '0; m_cnt = 0;
      e.ov = 1'b0;
    end else begin
      if (v) begin
        nb = 0;
        for (int i = 0; i < W; i++) begin
          int dv;
          dv = int'(av[i]) - int'(bv[i]);
          m_d[i]  = (dv != 0);
          m_br[i] = (dv < 0);
          if (dv < 0) nb++;
        end
        m_cnt = (m_cnt + nb > CMAX) ? CMAX : m_cnt + nb;
      end
      if (clr) m_cnt = 0;
      e.ov = v;
    end
    e.d  = m_d;
    e.br = m_br;
    e.c  = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v, input int cyc);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid",    int'(out_valid),    int'(e.ov), cyc);
        chk("diff",         int'(diff),         int'(e.d),  cyc);
        chk("borrow",       int'(borrow),       int'(e.br), cyc);
        chk("borrow_count", int'(borrow_count), int'(e.c),  cyc);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cnt_clr = 1'b0;

    // Reset with valid input present must still yield all zeros.
    step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);

    // Truth table lane by lane (all lanes same), then all combos across lanes.
    step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'b1100, 4'b1010, 1'b0);

    // Hold: inputs change while invalid.
    step(1'b1, 1'b1, 4'b0001, 4'b0011, 1'b0);
    step(1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);

    // Clear then multi-lane example, then saturation and clear-priority.
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 4'b0101, 4'b0011, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'b0011, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'h1, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b1);
    step(1'b1, 1'b1, 4'h0, 4'h3, 1'b0);

    // Mid-stream reset with in_valid held high.
    step(1'b1, 1'b1, 4'h0, 4'h7, 1'b0);
    step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'b0110, 4'b1010, 1'b0);
    step(1'b1, 1'b1, 4'h9, 4'h6, 1'b0);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
           W'($urandom), W'($urandom), $urandom_range(0, 24) == 0);
    end

    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
